// File: rtl/piradip_bit_packer_if.sv
// Handshake bundle for piradip_bit_packer.
//   in_bit/in_valid/in_ready      serial single-bit input stream
//   out_data/out_valid/out_ready  packed word output stream
// Modports: master = the environment that drives bits and consumes words,
//           slave  = the packer itself.
interface piradip_bit_packer_if #(
    parameter int WIDTH = 32
);
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/piradip_bit_packer.sv
// Packs a serial stream of single-bit samples into WIDTH-bit words.
// An accumulator collects bits while a separate output register holds the
// previous word, so bits can keep arriving at one per clock while a word
// waits to be consumed.
//
// Ports:
//   clk        sole clock, rising edge
//   aresetn    asynchronous active-low reset
//   io         piradip_bit_packer_if.slave (bit input stream, word output stream)
//   flush      pulse: emit the partial word        (PIRADIP_BIT_PACKER_FLUSH_EN only)
//   out_count  number of valid bits in out_data    (PIRADIP_BIT_PACKER_FLUSH_EN only)
//
// Parameters:
//   WIDTH      output word width, 2..64
//   LSB_FIRST  1: first bit lands in out_data[0]; 0: first bit lands in out_data[WIDTH-1]
//
// Build option: define PIRADIP_BIT_PACKER_FLUSH_EN to add the flush/out_count ports.
//
// state      | meaning
// FILL       | accumulator has room (cnt < WIDTH), input accepted
// FULL_WAIT  | accumulator holds a whole word, output slot still busy
// FLUSH_WAIT | flush requested, partial word waits for the output slot
module piradip_bit_packer #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       aresetn,
    piradip_bit_packer_if.slave        io
`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
    ,
    input  logic                       flush,
    output logic [$clog2(WIDTH+1)-1:0] out_count
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {FILL, FULL_WAIT, FLUSH_WAIT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, cnt_upd, pos;
    logic [WIDTH-1:0] acc, acc_nxt, acc_upd;
    logic [WIDTH-1:0] out_data_q, load_data;
    logic             out_valid_q;
    logic             accept, slot_free, completing, flush_ok, load;
    logic             flush_i;

`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
    logic [CW-1:0]    load_cnt;
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign io.in_ready  = (state == FILL);
    assign io.out_data  = out_data_q;
    assign io.out_valid = out_valid_q;

    assign accept     = io.in_valid && io.in_ready;
    assign slot_free  = !out_valid_q || io.out_ready;
    assign completing = accept && (cnt == CW'(WIDTH - 1));
    assign cnt_upd    = cnt + CW'(accept);
    assign pos        = LSB_FIRST ? cnt : (CW'(WIDTH - 1) - cnt);
    // A bit accepted in the flush cycle is part of the flushed word; the
    // completing bit already makes a whole word, so flush is moot there.
    assign flush_ok   = flush_i && (cnt_upd != '0) && !completing;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= FILL;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (completing && !slot_free) state_nxt = FULL_WAIT;
                else if (flush_ok)            state_nxt = FLUSH_WAIT;
            end
            FULL_WAIT:  if (slot_free) state_nxt = FILL;
            FLUSH_WAIT: if (slot_free) state_nxt = FILL;
            default:    state_nxt = FILL;
        endcase
    end

    always_comb begin
        acc_upd = acc;
        for (int i = 0; i < WIDTH; i++) begin
            if (accept && (CW'(i) == pos)) acc_upd[i] = io.in_bit;
        end
        load      = 1'b0;
        load_data = acc;
        cnt_nxt   = cnt_upd;
        acc_nxt   = acc_upd;
`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
        load_cnt  = CW'(WIDTH);
`endif
        case (state)
            FILL: begin
                if (completing && slot_free) begin
                    load      = 1'b1;
                    load_data = acc_upd;
                end
            end
            FULL_WAIT: load = slot_free;
            FLUSH_WAIT: begin
                load = slot_free;
`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
                load_cnt = cnt;
`endif
            end
            default: load = 1'b0;
        endcase
        // Clearing on every transfer keeps unfilled positions of a flushed word at 0.
        if (load) begin
            cnt_nxt = '0;
            acc_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt         <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            acc <= acc_nxt;
            if (load) begin
                out_data_q  <= load_data;
                out_valid_q <= 1'b1;
            end else if (io.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)  out_count <= '0;
        else if (load) out_count <= load_cnt;
    end
`endif
endmodule

// File: tb/tb_piradip_bit_packer.sv
module tb_piradip_bit_packer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    int   checks = 0;
    int   failures = 0;

    piradip_bit_packer_if #(.WIDTH(W)) if_l ();
    piradip_bit_packer_if #(.WIDTH(W)) if_m ();

    assign if_l.in_bit    = in_bit;
    assign if_l.in_valid  = in_valid;
    assign if_l.out_ready = out_ready;
    assign if_m.in_bit    = in_bit;
    assign if_m.in_valid  = in_valid;
    assign if_m.out_ready = out_ready;

`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
    logic       flush = 1'b0;
    logic [3:0] cnt_l, cnt_m;
`endif

    piradip_bit_packer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .aresetn(aresetn), .io(if_l)
`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
        , .flush(flush), .out_count(cnt_l)
`endif
    );

    piradip_bit_packer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .aresetn(aresetn), .io(if_m)
`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
        , .flush(flush), .out_count(cnt_m)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        checks++; if (if_l.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", if_l.out_valid); end
        checks++; if (if_l.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", if_l.out_data); end
        checks++; if (if_l.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", if_l.in_ready); end
        aresetn = 1'b1;
        @(negedge clk);
        checks++; if (if_l.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", if_l.in_ready); end
    endtask

    task automatic test_order();
        logic [7:0] seq;
        int ready_low;
        seq = 8'b1000_1101;   // seq[i] is the i-th bit sent: 1,0,1,1,0,0,0,1
        ready_low = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_l.in_ready !== 1'b1) ready_low++;
            if (i == 7) begin
                checks++; if (if_l.out_valid !== 1'b0) begin failures++; $display("FAIL order_early_valid got=%b exp=0", if_l.out_valid); end
            end
            in_valid = 1'b1;
            in_bit   = seq[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (if_l.out_valid !== 1'b1) begin failures++; $display("FAIL order_valid got=%b exp=1", if_l.out_valid); end
        checks++; if (if_l.out_data !== 8'h8D) begin failures++; $display("FAIL order_lsb_data got=%h exp=8d", if_l.out_data); end
        checks++; if (if_m.out_data !== 8'hB1) begin failures++; $display("FAIL order_msb_data got=%h exp=b1", if_m.out_data); end
        checks++; if (ready_low !== 0) begin failures++; $display("FAIL order_in_ready_low got=%0d exp=0", ready_low); end
`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
        checks++; if (cnt_l !== 4'd8) begin failures++; $display("FAIL order_out_count got=%0d exp=8", cnt_l); end
`endif
        @(negedge clk);
        checks++; if (if_l.out_valid !== 1'b0) begin failures++; $display("FAIL order_consumed got=%b exp=0", if_l.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] seq;
        int ready_low;
        seq = {8'h3C, 8'hA5};
        ready_low = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (if_l.in_ready !== 1'b1) ready_low++;
            in_valid = 1'b1;
            in_bit   = seq[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (ready_low !== 0) begin failures++; $display("FAIL bp_accept_all got=%0d exp=0", ready_low); end
        checks++; if (if_l.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b exp=0", if_l.in_ready); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_l.out_data !== 8'hA5 || if_l.out_valid !== 1'b1) begin failures++; $display("FAIL bp_word0_held got=%h/%b exp=a5/1", if_l.out_data, if_l.out_valid); end
        checks++; if (if_l.in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%b exp=0", if_l.in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (if_l.out_data !== 8'h3C || if_l.out_valid !== 1'b1) begin failures++; $display("FAIL bp_word1 got=%h/%b exp=3c/1", if_l.out_data, if_l.out_valid); end
        checks++; if (if_l.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_again got=%b exp=1", if_l.in_ready); end
        @(negedge clk);
        checks++; if (if_l.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", if_l.out_valid); end
    endtask

    task automatic test_random();
        logic [7:0] mw;
        logic [7:0] expq[$];
        logic [7:0] e;
        logic b;
        int ready_low, got;
        ready_low = 0;
        got = 0;
        mw = '0;
        out_ready = 1'b1;
        for (int i = 0; i <= 80; i++) begin
            @(negedge clk);
            if (if_l.in_ready !== 1'b1) ready_low++;
            if (if_l.out_valid === 1'b1) begin
                got++;
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rand_extra_word got=%h exp=none", if_l.out_data);
                end else begin
                    e = expq.pop_front();
                    checks++; if (if_l.out_data !== e) begin failures++; $display("FAIL rand_word got=%h exp=%h", if_l.out_data, e); end
                end
            end
            if (i < 80) begin
                b = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                in_bit   = b;
                mw[i % 8] = b;
                if (i % 8 == 7) expq.push_back(mw);
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++; if (got !== 10) begin failures++; $display("FAIL rand_word_count got=%0d exp=10", got); end
        checks++; if (ready_low !== 0) begin failures++; $display("FAIL rand_in_ready_low got=%0d exp=0", ready_low); end
    endtask

`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
    task automatic test_flush();
        logic [7:0] seq;
        out_ready = 1'b1;
        seq = 8'b0000_0011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = seq[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (if_l.in_ready !== 1'b0) begin failures++; $display("FAIL flush_pend_ready got=%b exp=0", if_l.in_ready); end
        @(negedge clk);
        checks++; if (if_l.out_valid !== 1'b1 || if_l.out_data !== 8'h03) begin failures++; $display("FAIL flush_word got=%h/%b exp=03/1", if_l.out_data, if_l.out_valid); end
        checks++; if (cnt_l !== 4'd3) begin failures++; $display("FAIL flush_count got=%0d exp=3", cnt_l); end
        checks++; if (if_m.out_data !== 8'hC0) begin failures++; $display("FAIL flush_msb_word got=%h exp=c0", if_m.out_data); end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++; if (if_l.out_valid !== 1'b0 || if_l.in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b/%b exp=0/1", if_l.out_valid, if_l.in_ready); end
        seq = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = seq[i];
            flush    = (i == 7);
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++; if (if_l.out_valid !== 1'b1 || if_l.out_data !== 8'h5A) begin failures++; $display("FAIL flush_full_word got=%h/%b exp=5a/1", if_l.out_data, if_l.out_valid); end
        checks++; if (cnt_l !== 4'd8) begin failures++; $display("FAIL flush_full_count got=%0d exp=8", cnt_l); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_l.out_valid !== 1'b0 || if_l.in_ready !== 1'b1) begin failures++; $display("FAIL flush_no_extra got=%b/%b exp=0/1", if_l.out_valid, if_l.in_ready); end
    endtask
`endif

    task automatic test_reset_midstream();
        int early;
        early = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (if_l.out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", if_l.out_valid); end
        #2 aresetn = 1'b0;
        #1;
        checks++; if (if_l.out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", if_l.out_valid); end
        checks++; if (if_l.in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%b exp=1", if_l.in_ready); end
        @(negedge clk);
        aresetn   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_l.out_valid !== 1'b0) early++;
            in_valid = 1'b1;
            in_bit   = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (early !== 0) begin failures++; $display("FAIL rst_stale_word got=%0d exp=0", early); end
        checks++; if (if_l.out_valid !== 1'b1 || if_l.out_data !== 8'hFF) begin failures++; $display("FAIL rst_fresh_word got=%h/%b exp=ff/1", if_l.out_data, if_l.out_valid); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_backpressure();
        test_random();
`ifdef PIRADIP_BIT_PACKER_FLUSH_EN
        test_flush();
`endif
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
